// File: rtl/mem_access_unit.sv
// mem_access_unit: turns core load/store requests into single-cycle
// data-memory strobes and returns a held response. Out-of-range
// addresses are answered directly with an error, and a saturating
// counter records how many such requests were accepted.
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | one cycle with the memory strobe asserted
// RESP   | response presented, waiting for resp_ready
module mem_access_unit #(
    parameter int MEM_DEPTH = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic       resp_error,
    output logic [7:0] address,
    output logic [7:0] writeData,
    input  logic [7:0] dataIn,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [7:0] error_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Nine bits so a MEM_DEPTH of 256 still compares correctly.
    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    state_t state, state_nxt;
    logic   wr_q;
    logic   accept;
    logic   in_range;

    assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
    assign accept   = req_valid && req_ready;

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        case (state)
            IDLE: begin
                // Held low during reset so nothing looks acceptable then.
                req_ready = ~reset;
                if (accept) begin
                    state_nxt = in_range ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                MemRead   = ~wr_q;
                MemWrite  = wr_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, captured request, memory-side registers and response data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            address     <= 8'd0;
            writeData   <= 8'd0;
            resp_rdata  <= 8'd0;
            resp_error  <= 1'b0;
            error_count <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q <= req_write;
                // address/writeData double as the registered request and
                // only move for accesses that really reach the memory.
                if (in_range) begin
                    address   <= req_addr;
                    writeData <= req_wdata;
                end else begin
                    resp_rdata <= 8'd0;
                    resp_error <= 1'b1;
                    if (error_count != 8'hFF) begin
                        error_count <= error_count + 8'd1;
                    end
                end
            end
            if (state == ACCESS) begin
                resp_rdata <= wr_q ? 8'd0 : dataIn;
                resp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random load/store traffic
// against a word-array memory model and a transaction-level reference.
module tb_mem_access_unit;

    localparam int MEM_DEPTH = 31;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_rdata;
    logic       resp_error;
    logic [7:0] address, writeData, dataIn;
    logic       MemRead, MemWrite;
    logic [7:0] error_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int         exp_errs;
    logic [7:0] last_addr, last_wdata;
    int         rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

    mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .address(address), .writeData(writeData), .dataIn(dataIn),
        .MemRead(MemRead), .MemWrite(MemWrite), .error_count(error_count)
    );

    always #5 clock = ~clock;

    // Data memory: writes on posedge, read data on negedge.
    always @(posedge clock) if (MemWrite) mem[address] <= writeData;
    always @(negedge clock) if (MemRead) dataIn <= mem[address];

    // Strobe monitor.
    always @(negedge clock) begin
        if (MemRead) rd_cnt++;
        if (MemWrite) wr_cnt++;
        if (MemRead && MemWrite) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction, checked cycle by cycle against the reference.
    task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d, input int hold);
        int         rd0, wr0, n;
        bit         err;
        logic [7:0] exp_rd;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        err = (int'(a) >= MEM_DEPTH);
        n = 0;
        while (!req_ready && n < 10) begin
            tick();
            n++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        tick();
        // Scramble request inputs right after acceptance.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        exp_rd = (err || w) ? 8'd0 : ref_mem[a];
        if (err) begin
            if (exp_errs < 255) exp_errs++;
        end else begin
            if (w) ref_mem[a] = d;
            last_addr  = a;
            last_wdata = d;
        end
        if (!err) begin
            chk("access_memread", MemRead, !w);
            chk("access_memwrite", MemWrite, w);
            chk("access_address", address, a);
            chk("access_wdata", writeData, d);
            chk("access_resp_valid", resp_valid, 0);
            chk("access_req_ready", req_ready, 0);
            tick();
        end else begin
            chk("err_no_memread", MemRead, 0);
            chk("err_no_memwrite", MemWrite, 0);
            chk("err_address_hold", address, last_addr);
            chk("err_wdata_hold", writeData, last_wdata);
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_error", resp_error, err);
        chk("error_count", error_count, exp_errs);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_resp_valid", resp_valid, 1);
            chk("hold_resp_rdata", resp_rdata, exp_rd);
            chk("hold_resp_error", resp_error, err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_memread", MemRead, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("done_resp_valid", resp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("read_strobes", rd_cnt - rd0, (!err && !w) ? 1 : 0);
        chk("write_strobes", wr_cnt - wr0, (!err && w) ? 1 : 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        dataIn = 8'd0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 8'd0; req_wdata = 8'd0; resp_ready = 1'b0;
        exp_errs = 0; last_addr = 8'd0; last_wdata = 8'd0;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_address", address, 0);
        chk("rst_wdata", writeData, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_error", resp_error, 0);
        chk("rst_error_count", error_count, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_req_ready", req_ready, 1);

        // Store then load.
        do_req(1'b1, 8'd5, 8'hA7, 0);
        do_req(1'b0, 8'd5, 8'h00, 0);
        // Range boundary.
        do_req(1'b0, 8'd31, 8'h00, 0);
        do_req(1'b0, 8'd30, 8'h00, 0);
        do_req(1'b1, 8'd255, 8'h11, 1);
        // Backpressure on a load of 0x3C.
        do_req(1'b1, 8'd12, 8'h3C, 0);
        do_req(1'b0, 8'd12, 8'h00, 5);

        // Reset during ACCESS of a load.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd7; req_wdata = 8'd0;
        tick();
        req_valid = 1'b0;
        chk("midrst_access", MemRead, 1);
        reset = 1'b1;
        tick();
        chk("midrst_memread", MemRead, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_address", address, 0);
        chk("midrst_error_count", error_count, 0);
        reset = 1'b0;
        exp_errs = 0; last_addr = 8'd0; last_wdata = 8'd0;
        tick();
        chk("midrst_req_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            resp_ready = 1'b1;
            tick();
            chk("midrst_no_stale", resp_valid, 0);
        end
        resp_ready = 1'b0;

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom), 8'($urandom_range(0, 40)), 8'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) begin
            do_req(1'($urandom), 8'($urandom_range(MEM_DEPTH, 255)), 8'($urandom), 0);
        end
        chk("sat_error_count", error_count, 255);
        do_req(1'b0, 8'd200, 8'd0, 0);
        chk("sat_hold", error_count, 255);

        chk("never_both_strobes", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
